// File: rtl/seq_pkg.sv
// Shared encodings and default sizes for the serial
// sequence generator and its matching detector.
package seq_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam int SEQ_CNT_W   = 4;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t IDLE = 2'd0;
    localparam seq_state_t SEND = 2'd1;
    localparam seq_state_t GAP  = 2'd2;
    localparam seq_state_t DONE = 2'd3;

endpackage

// File: rtl/sequence_generator.sv
// Serialises a captured bit pattern MSB-first, repeated
// a number of times with optional idle gaps in between.
module sequence_generator
    import seq_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = SEQ_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   pat_len,
    input  logic [CNT_W-1:0]   repeat_cnt,
    input  logic [CNT_W-1:0]   gap_len,
    output logic               ready,
    output logic               out_bit,
    output logic               out_valid,
    output logic               done
);

    localparam int LW = $clog2(MAX_LEN + 1);

    seq_state_t         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   gcnt_q, gcnt_d;
    logic [LW-1:0]      len_clamp;
    logic [LW-1:0]      sel;
    logic               bit_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
        end
    end

    always_comb begin
        len_clamp = LW'(pat_len);
        if (pat_len == '0)
            len_clamp = LW'(1);
        else if (int'(pat_len) > MAX_LEN)
            len_clamp = LW'(MAX_LEN);
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_clamp;
                    rep_d   = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    gap_d   = gap_len;
                    idx_d   = '0;
                    gcnt_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (idx_q == len_q - LW'(1)) begin
                    if (rep_q > CNT_W'(1)) begin
                        rep_d  = rep_q - CNT_W'(1);
                        idx_d  = '0;
                        gcnt_d = '0;
                        if (gap_q != '0)
                            state_d = GAP;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            GAP: begin
                if (gcnt_q == gap_q - CNT_W'(1)) begin
                    idx_d   = '0;
                    state_d = SEND;
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MSB-first: bit position counts down from len-1
    always_comb begin
        sel   = len_q - LW'(1) - idx_q;
        bit_c = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) == sel)
                bit_c = pat_q[i];
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign out_valid = (state_q == SEND);
    assign out_bit   = (state_q == SEND) & bit_c;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: table of jobs,
// scoreboard of expected bits, plus reset/start corner cases.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [3:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       ready;
    logic       out_bit;
    logic       out_valid;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int popped   = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0] pattern;
        logic [3:0] pat_len;
        logic [3:0] rep;
        logic [3:0] gap;
        int         exp_nbits;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[8];

    sequence_generator #(.MAX_LEN(8), .CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pattern(pattern),
        .pat_len(pat_len),
        .repeat_cnt(repeat_cnt),
        .gap_len(gap_len),
        .ready(ready),
        .out_bit(out_bit),
        .out_valid(out_valid),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Independent model of the clamped MSB-first stream
    task automatic push_bits(input logic [7:0] p, input int len, input int rep);
        int l;
        int r;
        l = (len == 0) ? 1 : (len > 8) ? 8 : len;
        r = (rep == 0) ? 1 : rep;
        for (int k = 0; k < r; k++)
            for (int i = 0; i < l; i++)
                exp_q.push_back(p[l-1-i]);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    chk("bit", int'(out_bit), int'(exp_q.pop_front()));
                    popped++;
                end
            end else begin
                chk("idle_out_bit", int'(out_bit), 0);
            end
        end
    end

    task automatic scramble();
        pattern    = 8'($urandom);
        pat_len    = 4'($urandom);
        repeat_cnt = 4'($urandom);
        gap_len    = 4'($urandom);
    endtask

    task automatic run_job(input int id, input vec_t v, input int mid);
        int cycles;
        bit got;
        @(negedge clk);
        chk($sformatf("v%0d_ready", id), int'(ready), 1);
        pattern    = v.pattern;
        pat_len    = v.pat_len;
        repeat_cnt = v.rep;
        gap_len    = v.gap;
        start      = 1'b1;
        popped     = 0;
        push_bits(v.pattern, int'(v.pat_len), int'(v.rep));
        @(posedge clk);
        cycles = 0;
        got    = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k == 0)
                scramble();
            if (done) begin
                got = 1'b1;
                break;
            end
            cycles++;
            start = (mid != 0 && cycles == mid);
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", id), int'(got), 1);
        chk($sformatf("v%0d_cycles", id), cycles, v.exp_cycles);
        chk($sformatf("v%0d_nbits", id), popped, v.exp_nbits);
        chk($sformatf("v%0d_ready_in_done", id), int'(ready), 0);
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", id), int'(done), 0);
        chk($sformatf("v%0d_ready_after", id), int'(ready), 1);
        exp_q.delete();
    endtask

    initial begin
        bit seen_done;
        vecs[0] = '{8'b0000_1011, 4'd4,  4'd1,  4'd0, 4,  4};
        vecs[1] = '{8'b0000_1011, 4'd4,  4'd2,  4'd0, 8,  8};
        vecs[2] = '{8'b0000_1011, 4'd4,  4'd2,  4'd2, 8,  10};
        vecs[3] = '{8'b0000_0001, 4'd0,  4'd1,  4'd0, 1,  1};
        vecs[4] = '{8'b1010_0101, 4'd12, 4'd1,  4'd3, 8,  8};
        vecs[5] = '{8'b0000_0110, 4'd3,  4'd0,  4'd1, 3,  3};
        vecs[6] = '{8'b1100_0011, 4'd8,  4'd3,  4'd1, 24, 26};
        vecs[7] = '{8'b0000_0010, 4'd2,  4'd15, 4'd15, 30, 240};

        reset = 1'b1;
        start = 1'b0;
        pattern = '0;
        pat_len = '0;
        repeat_cnt = '0;
        gap_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_bit", int'(out_bit), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        foreach (vecs[i])
            run_job(i, vecs[i], 0);

        // start pulsed mid-SEND must not disturb the stream
        run_job(8, vecs[2], 2);
        run_job(9, vecs[6], 5);

        // reset on the second bit discards the job
        @(negedge clk);
        pattern = 8'b0000_1011;
        pat_len = 4'd4;
        repeat_cnt = 4'd1;
        gap_len = 4'd0;
        start = 1'b1;
        push_bits(pattern, 4, 1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid_before", int'(out_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        chk("rst_mid_ready", int'(ready), 1);
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_done", int'(done), 0);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || out_valid)
                seen_done = 1'b1;
        end
        chk("rst_mid_no_done", int'(seen_done), 0);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_prio_ready", int'(ready), 1);
        chk("rst_prio_valid", int'(out_valid), 0);

        run_job(10, vecs[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
